esc_intr_bank: RTL and testbench

- Parametrised bank of NumChan escalation receivers with per-channel interrupt generation.
- Supersedes the fixed 4-channel NMI generator.
- Adds:
  - selectable sticky or level escalation latching
  - signal-integrity error detection and status
  - per-channel saturating escalation-duration counters
  - a simple word-addressed register port in place of the bus register top
- Sits beside the alert handler; receives its escalation diff-pairs and raises per-channel interrupts to the core.

---
 rtl/esc_intr_pkg.sv | 25 ++
 rtl/esc_chan_rx.sv | 63 ++++++
 rtl/esc_intr_bank.sv | 120 ++++++++++++
 tb/tb_esc_intr_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/esc_intr_pkg.sv
// Shared types and constants for the escalation interrupt bank.
package esc_intr_pkg;

  // Per-channel escalation receiver states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCheck  = 3'd1,
    StPing2  = 3'd2,
    StEsc    = 3'd3,
    StSigint = 3'd4
  } esc_rx_state_e;

  // Register word addresses; counters occupy AddrCntBase + k.
  localparam int unsigned AddrIntrState  = 0;
  localparam int unsigned AddrIntrEnable = 1;
  localparam int unsigned AddrIntrTest   = 2;
  localparam int unsigned AddrClear      = 3;
  localparam int unsigned AddrCntBase    = 4;

  // Diff-pair encodings as {p, n}.
  localparam logic [1:0] EscIdle   = 2'b01;
  localparam logic [1:0] EscActive = 2'b10;
  localparam logic [1:0] EscSigint = 2'b00;

endpackage

// File: rtl/esc_chan_rx.sv
// Single escalation receiver: wire decode, handshake FSM and response pair.
module esc_chan_rx
  import esc_intr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] esc_tx_i,
  output logic [1:0] esc_rx_o,
  output logic       esc_raw_o,
  output logic       sigint_evt_o
);

  esc_rx_state_e state_q, state_d;
  logic [1:0]    resp_d;
  logic          sigint_evt_d;
  logic          wire_active;
  logic          wire_sigint;

  assign wire_active = (esc_tx_i == EscActive);
  assign wire_sigint = (esc_tx_i[1] == esc_tx_i[0]);

  // Next state and next response; a sigint sample overrides every move.
  always_comb begin
    state_d      = state_q;
    resp_d       = EscIdle;
    sigint_evt_d = 1'b0;
    if (wire_sigint) begin
      state_d = StSigint;
    end else begin
      unique case (state_q)
        StIdle:   state_d = wire_active ? StCheck : StIdle;
        StCheck:  state_d = wire_active ? StEsc : StPing2;
        StPing2:  state_d = StIdle;
        StEsc:    state_d = wire_active ? StEsc : StIdle;
        StSigint: state_d = wire_active ? StCheck : StIdle;
        default:  state_d = StIdle;
      endcase
    end
    unique case (state_d)
      StCheck:  resp_d = EscActive;
      StEsc:    resp_d = ~esc_rx_o;  // continues the toggle begun by CHECK
      StSigint: resp_d = EscSigint;
      default:  resp_d = EscIdle;
    endcase
    sigint_evt_d = (state_d == StSigint) && (state_q != StSigint);
  end

  // State, response and sigint-entry pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      esc_rx_o     <= EscIdle;
      sigint_evt_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      esc_rx_o     <= resp_d;
      sigint_evt_o <= sigint_evt_d;
    end
  end

  assign esc_raw_o = (state_q == StEsc);

endmodule

// File: rtl/esc_intr_bank.sv
// Bank of escalation receivers with interrupts, duration counters and a register port.
module esc_intr_bank
  import esc_intr_pkg::*;
#(
  parameter int unsigned NumChan = 4,
  parameter int unsigned CntW    = 16,
  parameter bit          Sticky  = 1'b0,
  localparam int unsigned AddrW  = $clog2(NumChan + 4)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [2*NumChan-1:0] esc_tx_i,
  output logic [2*NumChan-1:0] esc_rx_o,
  output logic [NumChan-1:0]   esc_en_o,
  output logic [NumChan-1:0]   intr_o,
  input  logic                 reg_we_i,
  input  logic [AddrW-1:0]     reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic [31:0]          reg_rdata_o
);

  logic [NumChan-1:0] esc_raw;
  logic [NumChan-1:0] sigint_evt;
  logic [NumChan-1:0] esc_en;
  logic [NumChan-1:0] esc_en_q;
  logic [NumChan-1:0] esc_evt;
  logic [NumChan-1:0] intr_state_q;
  logic [NumChan-1:0] intr_enable_q;
  logic [NumChan-1:0] sigint_status_q;
  logic [CntW-1:0]    cnt_q [NumChan];

  logic               we_state, we_enable, we_test, we_clear;
  logic [NumChan-1:0] wdata;
  logic [NumChan-1:0] w1c, test_set, clr;
  logic               unused_wdata;

  // One receiver per channel.
  for (genvar k = 0; k < NumChan; k++) begin : g_chan
    esc_chan_rx u_rx (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .esc_tx_i     (esc_tx_i[2*k+:2]),
      .esc_rx_o     (esc_rx_o[2*k+:2]),
      .esc_raw_o    (esc_raw[k]),
      .sigint_evt_o (sigint_evt[k])
    );
  end

  // Write decode; bits at or above NumChan are dropped.
  assign wdata        = reg_wdata_i[NumChan-1:0];
  assign unused_wdata = ^reg_wdata_i;
  assign we_state     = reg_we_i && (reg_addr_i == AddrW'(AddrIntrState));
  assign we_enable    = reg_we_i && (reg_addr_i == AddrW'(AddrIntrEnable));
  assign we_test      = reg_we_i && (reg_addr_i == AddrW'(AddrIntrTest));
  assign we_clear     = reg_we_i && (reg_addr_i == AddrW'(AddrClear));
  assign w1c          = we_state ? wdata : '0;
  assign test_set     = we_test  ? wdata : '0;
  assign clr          = we_clear ? wdata : '0;

  // Escalation enable: follows the wire, or latched until cleared.
  if (Sticky) begin : g_sticky
    logic [NumChan-1:0] esc_latch_q;

    // Latch stays set while raw escalation is present, even across a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) esc_latch_q <= '0;
      else         esc_latch_q <= (esc_latch_q & ~clr) | esc_raw;
    end

    assign esc_en = esc_raw | esc_latch_q;
  end else begin : g_level
    assign esc_en = esc_raw;
  end

  assign esc_en_o = esc_en;
  assign esc_evt  = esc_en & ~esc_en_q;

  // Interrupt, enable and sigint status registers; hardware set beats W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      esc_en_q        <= '0;
      intr_state_q    <= '0;
      intr_enable_q   <= '0;
      sigint_status_q <= '0;
    end else begin
      esc_en_q        <= esc_en;
      intr_state_q    <= (intr_state_q & ~w1c) | esc_evt | sigint_evt | test_set;
      intr_enable_q   <= we_enable ? wdata : intr_enable_q;
      sigint_status_q <= (sigint_status_q & ~clr) | sigint_evt;
    end
  end

  // Saturating escalation-duration counters; clear with increment yields 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumChan; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NumChan; k++) begin
        if (clr[k]) begin
          cnt_q[k] <= esc_raw[k] ? CntW'(1) : '0;
        end else if (esc_raw[k] && (cnt_q[k] != '1)) begin
          cnt_q[k] <= cnt_q[k] + CntW'(1);
        end
      end
    end
  end

  assign intr_o = intr_state_q & intr_enable_q;

  // Combinational read mux; unmapped and write-only words read 0.
  always_comb begin
    reg_rdata_o = '0;
    if (reg_addr_i == AddrW'(AddrIntrState))  reg_rdata_o = 32'(intr_state_q);
    if (reg_addr_i == AddrW'(AddrIntrEnable)) reg_rdata_o = 32'(intr_enable_q);
    for (int unsigned k = 0; k < NumChan; k++) begin
      if (reg_addr_i == AddrW'(AddrCntBase + k)) reg_rdata_o = 32'(cnt_q[k]);
    end
  end

endmodule

// File: tb/tb_esc_intr_bank.sv
// Directed bench: dut0 is level-mode with 16-bit counters, dut1 is sticky with 4-bit counters.
module tb_esc_intr_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  tx0, rx0, tx1, rx1;
  logic [3:0]  en0, intr0, en1, intr1;
  logic        we0, we1;
  logic [2:0]  addr0, addr1;
  logic [31:0] wdata0, rdata0, wdata1, rdata1;

  esc_intr_bank #(.NumChan(4), .CntW(16), .Sticky(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .esc_tx_i(tx0), .esc_rx_o(rx0), .esc_en_o(en0),
    .intr_o(intr0), .reg_we_i(we0), .reg_addr_i(addr0), .reg_wdata_i(wdata0),
    .reg_rdata_o(rdata0)
  );

  esc_intr_bank #(.NumChan(4), .CntW(4), .Sticky(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .esc_tx_i(tx1), .esc_rx_o(rx1), .esc_en_o(en1),
    .intr_o(intr1), .reg_we_i(we1), .reg_addr_i(addr1), .reg_wdata_i(wdata1),
    .reg_rdata_o(rdata1)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic push_exp(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t item;
    if (sb.size() != 0) begin
      item = sb.pop_front();
    end else begin
      item.tag = "scoreboard_empty";
      item.exp = 'x;
    end
    n_total++;
    assert (obs === item.exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
  endtask

  task automatic chk(input string tag, input logic [31:0] e, input logic [31:0] obs);
    push_exp(tag, e);
    pop_chk(obs);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [31:0] d);
    addr0 = a; wdata0 = d; we0 = 1'b1;
    cyc();
    we0 = 1'b0;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [31:0] d);
    addr1 = a; wdata1 = d; we1 = 1'b1;
    cyc();
    we1 = 1'b0;
  endtask

  task automatic rd0(input logic [2:0] a, output logic [31:0] d);
    addr0 = a;
    #1;
    d = rdata0;
  endtask

  task automatic rd1(input logic [2:0] a, output logic [31:0] d);
    addr1 = a;
    #1;
    d = rdata1;
  endtask

  logic [31:0] rd;

  initial begin
    tx0 = 8'h55; tx1 = 8'h55;
    we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;

    // Reset values
    cyc(); cyc();
    chk("reset_rx0", 32'h55, 32'(rx0));
    chk("reset_en0", 32'h0, 32'(en0));
    chk("reset_intr0", 32'h0, 32'(intr0));
    chk("reset_rx1", 32'h55, 32'(rx1));
    rst_n = 1'b1;
    cyc();

    // Ping on ch0: one active cycle then idle
    tx0[1:0] = 2'b10;
    cyc();
    chk("ping_resp_check", 32'h2, 32'(rx0[1:0]));
    tx0[1:0] = 2'b01;
    cyc();
    chk("ping_resp_ping2", 32'h1, 32'(rx0[1:0]));
    chk("ping_en", 32'h0, 32'(en0));
    cyc();
    chk("ping_resp_idle", 32'h1, 32'(rx0[1:0]));
    rd0(3'd4, rd);
    chk("ping_cnt0", 32'h0, rd);
    rd0(3'd0, rd);
    chk("ping_intr_state", 32'h0, rd);

    // Escalation on ch2 for 5 cycles, level mode
    wr0(3'd1, 32'h4);
    for (int i = 0; i < 5; i++) begin
      push_exp($sformatf("esc2_resp_%0d", i), (i % 2 == 0) ? 32'h2 : 32'h1);
      push_exp($sformatf("esc2_en_%0d", i), (i == 0) ? 32'h0 : 32'h4);
    end
    tx0[5:4] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      cyc();
      pop_chk(32'(rx0[5:4]));
      pop_chk(32'(en0));
    end
    tx0[5:4] = 2'b01;
    cyc();
    chk("esc2_resp_idle", 32'h1, 32'(rx0[5:4]));
    chk("esc2_en_off", 32'h0, 32'(en0));
    chk("esc2_intr", 32'h4, 32'(intr0));
    rd0(3'd6, rd);
    chk("esc2_cnt2", 32'd4, rd);
    wr0(3'd0, 32'h4);
    chk("esc2_w1c_intr", 32'h0, 32'(intr0));

    // Sticky escalation on dut1 ch1 for 3 cycles
    tx1[3:2] = 2'b10;
    cyc(); cyc(); cyc();
    tx1[3:2] = 2'b01;
    cyc(); cyc(); cyc();
    chk("sticky_en_held", 32'h2, 32'(en1));
    rd1(3'd5, rd);
    chk("sticky_cnt1", 32'd2, rd);
    wr1(3'd3, 32'h2);
    chk("sticky_en_cleared", 32'h0, 32'(en1));
    rd1(3'd5, rd);
    chk("sticky_cnt1_cleared", 32'h0, rd);

    // Signal-integrity error on dut0 ch3
    tx0[7:6] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("sigint_resp_%0d", i), 32'h0, 32'(rx0[7:6]));
    end
    rd0(3'd0, rd);
    chk("sigint_intr_state", 32'h8, rd);
    chk("sigint_status", 32'h8, 32'(dut0.sigint_status_q));
    chk("sigint_intr_masked", 32'h0, 32'(intr0));
    tx0[7:6] = 2'b01;
    cyc();
    chk("sigint_resp_idle", 32'h1, 32'(rx0[7:6]));
    wr0(3'd3, 32'h8);
    chk("sigint_status_clr", 32'h0, 32'(dut0.sigint_status_q));

    // Clear in the same cycle as an increment leaves the counter at 1
    tx0[3:2] = 2'b10;
    cyc(); cyc();
    wr0(3'd3, 32'h2);
    rd0(3'd5, rd);
    chk("clr_inc_cnt1", 32'd1, rd);
    tx0[3:2] = 2'b01;
    cyc(); cyc();
    wr0(3'd0, 32'hF);
    rd0(3'd0, rd);
    chk("w1c_all", 32'h0, rd);

    // Counter saturation with 4-bit counters on dut1 ch0
    tx1[1:0] = 2'b10;
    for (int i = 0; i < 20; i++) cyc();
    rd1(3'd4, rd);
    chk("sat_cnt_active", 32'd15, rd);
    tx1[1:0] = 2'b01;
    cyc(); cyc();
    rd1(3'd4, rd);
    chk("sat_cnt_hold", 32'd15, rd);

    // INTR_TEST sets a state bit without escalation
    wr0(3'd2, 32'h1);
    rd0(3'd0, rd);
    chk("test_intr_state", 32'h1, rd);
    rd0(3'd2, rd);
    chk("test_reads_zero", 32'h0, rd);
    wr0(3'd1, 32'h1);
    chk("test_intr_out", 32'h1, 32'(intr0));

    // Asynchronous reset in the middle of escalation on all channels
    tx0 = 8'hAA; tx1 = 8'hAA;
    cyc(); cyc(); cyc();
    chk("pre_reset_en0", 32'hF, 32'(en0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rx0", 32'h55, 32'(rx0));
    chk("async_rst_en0", 32'h0, 32'(en0));
    chk("async_rst_intr0", 32'h0, 32'(intr0));
    chk("async_rst_rx1", 32'h55, 32'(rx1));
    chk("async_rst_en1", 32'h0, 32'(en1));
    tx0 = 8'h55; tx1 = 8'h55;
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    chk("post_rst_intr0", 32'h0, 32'(intr0));
    chk("post_rst_intr1", 32'h0, 32'(intr1));
    rd0(3'd0, rd);
    chk("post_rst_state0", 32'h0, rd);
    rd1(3'd0, rd);
    chk("post_rst_state1", 32'h0, rd);
    chk("post_rst_en1", 32'h0, 32'(en1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
